event_dispatcher: RTL and testbench
===================================

# event_dispatcher

Pulls time-stamped events out of the Event Queue and hands them to the evaluation stage, which sits directly downstream. It owns simulation time: the dispatcher issues read requests on the queue's `op`/`cs` port and captures `EV_out` on `dv`. It presents each event on a valid/ready port and advances `sim_time` only after the evaluator reports that the current time step is finished. It also stops at a programmable end time and flags causality violations (events older than the current time).

## Interface
- `data_wd`, 32: event entry width; same value as the Event Queue.
- `hi`, 15: TIME field high bit inside the entry.
- `lo`, 0: TIME field low bit; time width `tw = hi-lo+1`.
- `rd_op`, 1'b0: value driven on `eq_op` to request a read.
- `cnt_wd`, 16: width of the dispatched-event counter.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `run` in 1: level; when 0, no new reads are issued.
- `stop_time` in tw: last simulation time that may be dispatched.
- `eq_ev` in data_wd: from queue `EV_out`.
- `eq_dv` in 1: from queue `dv`.
- `eq_empty` in 1: from queue `empty`.
- `eq_busy_rd` in 1: from queue `busy_for_rd`.
- `eq_op` out 1: to queue `op`; constant `rd_op`.
- `eq_cs` out 1: to queue `cs`; one-cycle read strobe.
- `ev_out` out data_wd: event presented to the evaluator.
- `ev_valid` out 1: `ev_out` is valid.
- `ev_ready` in 1: the evaluator accepts the event.
- `eval_idle` in 1: the evaluator has no pending work at `sim_time`.
- `sim_time` out tw: current simulation time.
- `time_adv` out 1: one-cycle pulse when `sim_time` changes.
- `late_err` out 1: sticky causality-violation flag.
- `done` out 1: sticky; set when the next event's time exceeds `stop_time`.
- `ev_count` out cnt_wd: number of events transferred, wrapping.

## Operation
- Reset values: `eq_cs`=0, `ev_valid`=0, `ev_out`=0, `sim_time`=0, `time_adv`=0, `late_err`=0, `done`=0, `ev_count`=0, state=IDLE. Reset takes effect from any state and discards any held event.
- `eq_op` is always `rd_op`.
- The time of an event `e` is `e[hi:lo]`, treated as unsigned.

State machine:
- **IDLE**
  - Condition: `run && !eq_empty && !eq_busy_rd && !done`.
  - Action: go to REQ.
  - `eq_dv` seen in IDLE is ignored. This covers a stale response from a read issued before reset.
- **REQ**
  - Action: drive `eq_cs`=1 for exactly this cycle, then go to WAIT.
- **WAIT**
  - On `eq_dv`=1: latch `eq_ev` into the hold register.
  - Let `t` be its time:
    - `t > stop_time`: set `done`, keep the event held, go to IDLE. `done` blocks further reads; a reset is required to leave this condition.
    - `t < sim_time`: set `late_err`, go to DISP. `sim_time` is unchanged.
    - `t == sim_time`: go to DISP.
    - `t > sim_time`: go to ADV.
- **ADV**
  - Wait for `eval_idle`=1.
  - Then, in one cycle: `sim_time <= t`, `time_adv`=1 next cycle, go to DISP.
- **DISP**
  - `ev_valid`=1, `ev_out` = hold register. Both are stable until the transfer.
  - On `ev_valid && ev_ready`: `ev_count++` (wraps), `ev_valid` drops next cycle, go to IDLE.
- `run` falling does not abort an in-flight read or a held event. The machine completes to IDLE and stops there.

## Timing
- Read request to capture: `eq_cs` is asserted in cycle N; `eq_dv` may come in N+1 or later, with unbounded wait.
- Capture to valid:
  - `eq_dv` in cycle M with `t == sim_time`: `ev_valid`=1 in M+1.
  - `t > sim_time` with `eval_idle`=1 already: `sim_time` updates in M+2 and `ev_valid`=1 in M+2.
- Throughput: at most one event per 4 cycles (IDLE → REQ → WAIT → DISP).
- `time_adv` is high exactly one cycle, coincident with the new `sim_time` value.
- `done` and `late_err` change only on the cycle after the capture.
- `ev_ready` is ignored while `ev_valid`=0.

## Test plan
- **Reset and idle:** reset, then `eq_empty`=1 with `run`=1 → `eq_cs` never asserts; all outputs at their reset values.
- **Same-time dispatch:** queue returns time 0 with `dv` one cycle after `cs`, `ev_ready`=1 → `ev_valid` for one cycle, `ev_count`=1, `sim_time`=0, no `time_adv`.
- **Time advance gated by `eval_idle`:** event at time 5 while `sim_time`=0 and `eval_idle`=0 for 10 cycles → no `ev_valid` for those 10 cycles. Then `eval_idle`=1 → `sim_time`=5, `time_adv` pulse, and `ev_valid` in the same cycle.
- **Backpressure:** `ev_ready`=0 for 7 cycles → `ev_out` is constant, `ev_valid` stays high, and no `eq_cs` is issued. Transfer happens on the first ready cycle.
- **Late event and stop:**
  - With `sim_time`=5, an event at time 3 → `late_err`=1 and the event is still dispatched.
  - `stop_time`=8 and an event at time 9 → `done`=1, no dispatch, no further `eq_cs`.
- **Mid-operation reset:** assert `rst` in WAIT; the queue asserts `eq_dv` one cycle after `rst` is released → the response is ignored, the FSM stays in IDLE, and `ev_valid`=0.

Source files
------------

// File: rtl/event_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : event_dispatcher
// Purpose  : Pulls time-stamped events from the Event Queue one at a time,
//            owns simulation time, and hands each event to the evaluator on a
//            valid/ready port. Time only moves forward once the evaluator
//            reports it is idle. Stops at a programmable end time and flags
//            events older than the current time.
// Ports    : clk, rst           - clock, synchronous active-high reset
//            run, stop_time     - enable for new reads, last dispatchable time
//            eq_ev/eq_dv/eq_empty/eq_busy_rd - queue read response and status
//            eq_op/eq_cs        - queue read command (op constant, cs strobe)
//            ev_out/ev_valid/ev_ready - event handoff to the evaluator
//            eval_idle          - evaluator finished with the current time
//            sim_time/time_adv  - current time and one-cycle change pulse
//            late_err/done      - sticky causality and end-of-run flags
//            ev_count           - wrapping count of transferred events
// Revision : 1.0 - initial release
// ============================================================================
module event_dispatcher #(
   parameter int   data_wd = 32,
   parameter int   hi      = 15,
   parameter int   lo      = 0,
   parameter logic rd_op   = 1'b0,
   parameter int   cnt_wd  = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               run,
   input  logic [hi-lo:0]     stop_time,
   input  logic [data_wd-1:0] eq_ev,
   input  logic               eq_dv,
   input  logic               eq_empty,
   input  logic               eq_busy_rd,
   output logic               eq_op,
   output logic               eq_cs,
   output logic [data_wd-1:0] ev_out,
   output logic               ev_valid,
   input  logic               ev_ready,
   input  logic               eval_idle,
   output logic [hi-lo:0]     sim_time,
   output logic               time_adv,
   output logic               late_err,
   output logic               done,
   output logic [cnt_wd-1:0]  ev_count
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_REQ  = 3'd1,
      S_WAIT = 3'd2,
      S_ADV  = 3'd3,
      S_DISP = 3'd4
   } state_t;

   localparam logic [cnt_wd-1:0] cnt_one = {{(cnt_wd-1){1'b0}}, 1'b1};

   state_t             state;
   state_t             next_state;
   logic [data_wd-1:0] hold;
   logic [hi-lo:0]     in_time;
   logic [hi-lo:0]     hold_time;

   assign in_time   = eq_ev[hi:lo];
   assign hold_time = hold[hi:lo];
   assign eq_op     = rd_op;
   assign ev_out    = hold;

   // ------------------------------------------------------------------------
   // Next state and Moore outputs
   // ------------------------------------------------------------------------
   always_comb begin
      next_state = state;
      eq_cs      = 1'b0;
      ev_valid   = 1'b0;
      case (state)
         S_IDLE: begin
            // A response arriving here belongs to a read cut short by reset.
            if (run && !eq_empty && !eq_busy_rd && !done)
               next_state = S_REQ;
         end
         S_REQ: begin
            eq_cs      = 1'b1;
            next_state = S_WAIT;
         end
         S_WAIT: begin
            if (eq_dv) begin
               if (in_time > stop_time)
                  next_state = S_IDLE;
               else if (in_time > sim_time)
                  next_state = S_ADV;
               else
                  next_state = S_DISP;   // same time, or late
            end
         end
         S_ADV: begin
            if (eval_idle)
               next_state = S_DISP;
         end
         S_DISP: begin
            ev_valid = 1'b1;
            if (ev_ready)
               next_state = S_IDLE;
         end
         default: next_state = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // State register and datapath
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         hold     <= '0;
         sim_time <= '0;
         time_adv <= 1'b0;
         late_err <= 1'b0;
         done     <= 1'b0;
         ev_count <= '0;
      end else begin
         state    <= next_state;
         time_adv <= 1'b0;

         if (state == S_WAIT && eq_dv) begin
            hold <= eq_ev;
            // Past the end time: the event stays held but is never offered.
            if (in_time > stop_time)
               done <= 1'b1;
            else if (in_time < sim_time)
               late_err <= 1'b1;
         end

         if (state == S_ADV && eval_idle) begin
            sim_time <= hold_time;
            time_adv <= 1'b1;
         end

         if (state == S_DISP && ev_ready)
            ev_count <= ev_count + cnt_one;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_event_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_event_dispatcher
// Purpose  : Self-checking bench for event_dispatcher. The bench plays the
//            Event Queue and the evaluator, and keeps a small model of
//            simulation time, event count and the sticky flags.
// Revision : 1.0 - initial release
// ============================================================================
module tb_event_dispatcher;

   logic        clk = 1'b0;
   logic        rst;
   logic        run;
   logic [15:0] stop_time;
   logic [31:0] eq_ev;
   logic        eq_dv;
   logic        eq_empty;
   logic        eq_busy_rd;
   logic        eq_op;
   logic        eq_cs;
   logic [31:0] ev_out;
   logic        ev_valid;
   logic        ev_ready;
   logic        eval_idle;
   logic [15:0] sim_time;
   logic        time_adv;
   logic        late_err;
   logic        done;
   logic [15:0] ev_count;

   event_dispatcher #(
      .data_wd(32), .hi(15), .lo(0), .rd_op(1'b0), .cnt_wd(16)
   ) dut (
      .clk(clk), .rst(rst), .run(run), .stop_time(stop_time),
      .eq_ev(eq_ev), .eq_dv(eq_dv), .eq_empty(eq_empty),
      .eq_busy_rd(eq_busy_rd), .eq_op(eq_op), .eq_cs(eq_cs),
      .ev_out(ev_out), .ev_valid(ev_valid), .ev_ready(ev_ready),
      .eval_idle(eval_idle), .sim_time(sim_time), .time_adv(time_adv),
      .late_err(late_err), .done(done), .ev_count(ev_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // reference model state
   int unsigned exp_sim;
   int unsigned exp_count;
   logic        exp_late;
   logic        exp_done;

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      exp_sim   = 0;
      exp_count = 0;
      exp_late  = 1'b0;
      exp_done  = 1'b0;
   endtask

   // One full read/dispatch transaction; starts with the DUT in IDLE.
   task automatic do_event(input logic [31:0] ev, input int busy_n,
                           input int dv_n, input int idle_n, input int rdy_n);
      int unsigned t;
      logic        got;
      t = int'(ev[15:0]);

      eq_busy_rd = 1'b1;
      for (int i = 0; i < busy_n; i++) begin
         check("busy_no_cs", eq_cs, 1'b0);
         tick();
      end
      eq_busy_rd = 1'b0;

      got = 1'b0;
      for (int i = 0; i < 6 && !got; i++) begin
         if (eq_cs) got = 1'b1;
         else tick();
      end
      check("cs_seen", got, 1'b1);

      eq_ev    = $urandom;
      ev_ready = 1'b1;              // ignored while nothing is valid
      tick();
      check("cs_one_cycle", eq_cs, 1'b0);
      for (int i = 1; i < dv_n; i++) begin
         eq_ev = $urandom;
         tick();
      end

      eval_idle = (idle_n == 0);
      eq_dv     = 1'b1;
      eq_ev     = ev;
      tick();
      eq_dv    = 1'b0;
      eq_ev    = $urandom;
      ev_ready = 1'b0;
      check("count_no_valid", ev_count, exp_count[15:0]);

      if (t > int'(stop_time)) begin
         exp_done = 1'b1;
         check("done_set", done, exp_done);
         for (int i = 0; i < 6; i++) begin
            check("done_no_valid", ev_valid, 1'b0);
            check("done_no_cs", eq_cs, 1'b0);
            tick();
         end
         check("done_sim_time", sim_time, exp_sim[15:0]);
         return;
      end

      if (t < exp_sim) exp_late = 1'b1;
      check("late_err", late_err, exp_late);
      check("done_clear", done, exp_done);

      if (t > exp_sim) begin
         for (int i = 0; i < idle_n; i++) begin
            check("adv_no_valid", ev_valid, 1'b0);
            check("adv_sim_hold", sim_time, exp_sim[15:0]);
            ev_ready = 1'($urandom);
            tick();
            ev_ready = 1'b0;
            check("adv_count", ev_count, exp_count[15:0]);
         end
         eval_idle = 1'b1;
         check("adv_last_no_valid", ev_valid, 1'b0);
         tick();
         exp_sim = t;
         check("time_adv_pulse", time_adv, 1'b1);
      end else begin
         check("no_time_adv", time_adv, 1'b0);
      end
      check("sim_time", sim_time, exp_sim[15:0]);

      for (int i = 0; i < rdy_n; i++) begin
         check("bp_valid", ev_valid, 1'b1);
         check("bp_ev_out", ev_out, ev);
         check("bp_no_cs", eq_cs, 1'b0);
         tick();
      end
      ev_ready = 1'b1;
      check("disp_valid", ev_valid, 1'b1);
      check("disp_ev_out", ev_out, ev);
      tick();
      ev_ready  = 1'b0;
      exp_count = exp_count + 1;
      check("valid_drop", ev_valid, 1'b0);
      check("ev_count", ev_count, exp_count[15:0]);
      check("time_adv_one_cycle", time_adv, 1'b0);
   endtask

   initial begin
      logic        got;
      int unsigned t;
      int          r;

      rst        = 1'b1;
      run        = 1'b1;
      stop_time  = 16'hFFFF;
      eq_ev      = '0;
      eq_dv      = 1'b0;
      eq_empty   = 1'b1;
      eq_busy_rd = 1'b0;
      ev_ready   = 1'b0;
      eval_idle  = 1'b1;
      model_reset();
      repeat (3) tick();
      rst = 1'b0;

      // Reset state and idle with an empty queue
      check("rst_eq_op", eq_op, 1'b0);
      check("rst_ev_valid", ev_valid, 1'b0);
      check("rst_ev_out", ev_out, 32'h0);
      check("rst_sim_time", sim_time, 16'h0);
      check("rst_time_adv", time_adv, 1'b0);
      check("rst_late_err", late_err, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_ev_count", ev_count, 16'h0);
      for (int i = 0; i < 10; i++) begin
         check("empty_no_cs", eq_cs, 1'b0);
         tick();
      end
      eq_empty = 1'b0;

      // Same-time dispatch
      do_event(32'hA5A5_0000, 0, 1, 0, 0);
      // Time advance held off by a busy evaluator
      do_event(32'h1234_0005, 2, 1, 10, 0);
      // Backpressure
      do_event(32'h5678_0005, 0, 2, 0, 7);
      // Late event is flagged and still dispatched
      do_event(32'h9ABC_0003, 0, 1, 0, 1);
      // Event past the stop time
      stop_time = 16'd8;
      do_event(32'hDEAD_0009, 0, 1, 0, 0);

      // Mid-operation reset with a stale response afterwards
      rst = 1'b1;
      tick();
      rst = 1'b0;
      model_reset();
      stop_time = 16'hFFFF;
      got = 1'b0;
      for (int i = 0; i < 6 && !got; i++) begin
         if (eq_cs) got = 1'b1;
         else tick();
      end
      check("mr_cs_seen", got, 1'b1);
      tick();                          // now waiting for the response
      run = 1'b0;
      rst = 1'b1;
      tick();
      rst   = 1'b0;
      eq_dv = 1'b1;
      eq_ev = 32'h0BAD_0002;
      tick();
      check("mr_no_valid_a", ev_valid, 1'b0);
      tick();
      eq_dv = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("mr_no_valid", ev_valid, 1'b0);
         check("mr_no_cs", eq_cs, 1'b0);
         tick();
      end
      check("mr_sim_time", sim_time, 16'h0);
      check("mr_count", ev_count, 16'h0);
      check("mr_ev_out", ev_out, 32'h0);
      run = 1'b1;

      // Randomized traffic against the model
      for (int n = 0; n < 30; n++) begin
         r = int'($urandom_range(0, 9));
         if (r < 2 && exp_sim > 0)
            t = exp_sim - $urandom_range(1, (exp_sim < 3) ? exp_sim : 3);
         else if (r < 5)
            t = exp_sim;
         else
            t = exp_sim + $urandom_range(1, 4);
         do_event({16'($urandom), t[15:0]}, int'($urandom_range(0, 2)),
                  int'($urandom_range(1, 3)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 2)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
